seg7_scan_decoder: RTL and testbench

//   Receive end of the 7-segment display interface: samples a multiplexed (scanned) segment bus plus
//   one-hot digit strobes and reconstructs the BCD value of every digit. Each pattern must be stable
//   for a set time (deglitch) before it is accepted. Used to check display drivers in-system and to

---
 rtl/seg7_scan_decoder.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment bus receiver: deglitches each (segments, strobe) pattern, decodes it to BCD
// and publishes the per-digit register bank plus a valid/ready stream of changed digits.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [DIGITS-1:0]   dig_sel,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                err_flag,
    input  logic                err_clr,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [2:0]          upd_idx,
    output logic [3:0]          upd_bcd,
    output logic                upd_ovf
);

    localparam int            CW           = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_DONE     = CW'(STABLE_CYC);
    localparam logic [3:0]    CODE_BLANK   = 4'hF;
    localparam logic [3:0]    CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h7E:   code = 4'd0;
            7'h30:   code = 4'd1;
            7'h6D:   code = 4'd2;
            7'h79:   code = 4'd3;
            7'h33:   code = 4'd4;
            7'h5B:   code = 4'd5;
            7'h5F:   code = 4'd6;
            7'h70:   code = 4'd7;
            7'h7F:   code = 4'd8;
            7'h7B:   code = 4'd9;
            7'h00:   code = CODE_BLANK;
            default: code = CODE_INVALID;
        endcase
        return code;
    endfunction

    logic [6:0]             seg_s_q, seg_p_q;
    logic [DIGITS-1:0]      sel_s_q, sel_p_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]      valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   upd_valid_q, upd_valid_d;
    logic [2:0]             upd_idx_q, upd_idx_d;
    logic [3:0]             upd_bcd_q, upd_bcd_d;
    logic                   ovf_q, ovf_d;

    logic                   s_onehot, s_same, capture, new_upd;
    logic [3:0]             cap_code;
    logic [2:0]             cap_idx;

    assign s_onehot = $onehot(sel_s_q);
    assign s_same   = (seg_s_q == seg_p_q) && (sel_s_q == sel_p_q);
    assign cap_code = seg_decode(seg_s_q);

    // NOTE: every variable driven in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_onehot) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!s_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!s_same) begin
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s_same) begin
                    state_d = s_onehot ? SETTLE : IDLE;
                    cnt_d   = s_onehot ? CNT_ONE : '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Reaching the threshold captures the current sample; with STABLE_CYC=1 that is the first one.
        if (state_d == SETTLE && cnt_d == CNT_DONE) begin
            capture = 1'b1;
            state_d = HELD;
        end
    end

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_s_q[i]) cap_idx = 3'(i);
        end
    end

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = valid_q;
        new_upd = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && sel_s_q[i]) begin
                bcd_d[i]   = cap_code;
                valid_d[i] = (cap_code <= 4'd9);
                new_upd    = (cap_code != bcd_q[i]);
            end
        end

        err_d = (capture && cap_code == CODE_INVALID) || (err_q && !err_clr);

        upd_valid_d = upd_valid_q;
        upd_idx_d   = upd_idx_q;
        upd_bcd_d   = upd_bcd_q;
        ovf_d       = ovf_q && !err_clr;
        if (new_upd) begin
            upd_valid_d = 1'b1;
            upd_idx_d   = cap_idx;
            upd_bcd_d   = cap_code;
            if (upd_valid_q && !upd_ready) ovf_d = 1'b1;
        end else if (upd_valid_q && upd_ready) begin
            upd_valid_d = 1'b0;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s_q     <= '0;
            sel_s_q     <= '0;
            seg_p_q     <= '0;
            sel_p_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            // NOTE: the digit bank is reset (to blank) because consumers read it before any capture.
            bcd_q       <= '1;
            valid_q     <= '0;
            err_q       <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_bcd_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            seg_s_q     <= seg_in;
            sel_s_q     <= dig_sel;
            seg_p_q     <= seg_s_q;
            sel_p_q     <= sel_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_bcd_q   <= upd_bcd_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = valid_q;
    assign err_flag    = err_q;
    assign upd_valid   = upd_valid_q;
    assign upd_idx     = upd_idx_q;
    assign upd_bcd     = upd_bcd_q;
    assign upd_ovf     = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: table of dwell vectors plus hand sequences for error, handshake and
// reset corners; accepted updates are checked against a queue of expected (idx, code) pairs.
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                err_flag;
    logic                err_clr;
    logic                upd_valid;
    logic                upd_ready;
    logic [2:0]          upd_idx;
    logic [3:0]          upd_bcd;
    logic                upd_ovf;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .err_flag    (err_flag),
        .err_clr     (err_clr),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_bcd     (upd_bcd),
        .upd_ovf     (upd_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        int         dwell;
        int         gap;
        int         idx;
        logic [3:0] code;
        bit         upd;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] code;
    } upd_t;

    upd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [6:0] seg, input logic [3:0] sel, input int n);
        seg_in  = seg;
        dig_sel = sel;
        repeat (n) step();
    endtask

    task automatic push(input int idx, input logic [3:0] code);
        upd_t u;
        u.idx  = 3'(idx);
        u.code = code;
        exp_q.push_back(u);
    endtask

    // Scoreboard: an update is consumed on the edge following a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && upd_valid === 1'b1 && upd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL upd_unexpected: got idx %0d bcd %0h expected no update", upd_idx, upd_bcd);
            end else begin
                upd_t e;
                e = exp_q.pop_front();
                check("upd_idx", 32'(upd_idx), 32'(e.idx));
                check("upd_bcd", 32'(upd_bcd), 32'(e.code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{7'h7E, 4'b0001, 5, 2, 0, 4'h0, 1'b1};
        vecs[1]  = '{7'h30, 4'b0001, 6, 0, 0, 4'h1, 1'b1};
        vecs[2]  = '{7'h6D, 4'b0010, 6, 0, 1, 4'h2, 1'b1};
        vecs[3]  = '{7'h79, 4'b0100, 6, 0, 2, 4'h3, 1'b1};
        vecs[4]  = '{7'h33, 4'b1000, 6, 0, 3, 4'h4, 1'b1};
        vecs[5]  = '{7'h30, 4'b0001, 6, 0, 0, 4'h1, 1'b0};
        vecs[6]  = '{7'h6D, 4'b0010, 6, 0, 1, 4'h2, 1'b0};
        vecs[7]  = '{7'h79, 4'b0100, 6, 0, 2, 4'h3, 1'b0};
        vecs[8]  = '{7'h33, 4'b1000, 6, 0, 3, 4'h4, 1'b0};
        vecs[9]  = '{7'h5B, 4'b0010, 3, 2, 1, 4'h2, 1'b0};
        vecs[10] = '{7'h5B, 4'b0010, 4, 2, 1, 4'h5, 1'b1};
        vecs[11] = '{7'h00, 4'b1000, 6, 2, 3, 4'hF, 1'b1};
        vecs[12] = '{7'h7F, 4'b0011, 6, 2, 0, 4'h1, 1'b0};
        vecs[13] = '{7'h30, 4'b1000, 2, 0, 3, 4'hF, 1'b0};
        vecs[14] = '{7'h7F, 4'b1000, 2, 0, 3, 4'hF, 1'b0};
        vecs[15] = '{7'h30, 4'b1000, 6, 2, 3, 4'h1, 1'b1};
        vecs[16] = '{7'h5F, 4'b0001, 6, 2, 0, 4'h6, 1'b1};
        vecs[17] = '{7'h70, 4'b0010, 6, 2, 1, 4'h7, 1'b1};
        vecs[18] = '{7'h7B, 4'b0100, 6, 2, 2, 4'h9, 1'b1};

        rst_n     = 1'b0;
        seg_in    = '0;
        dig_sel   = '0;
        err_clr   = 1'b0;
        upd_ready = 1'b1;
        repeat (3) step();
        check("rst_bcd_out", 32'(bcd_out), 32'hFFFF);
        check("rst_digit_valid", 32'(digit_valid), 32'h0);
        check("rst_err_flag", 32'(err_flag), 32'h0);
        check("rst_upd_valid", 32'(upd_valid), 32'h0);
        check("rst_upd_idx", 32'(upd_idx), 32'h0);
        check("rst_upd_bcd", 32'(upd_bcd), 32'h0);
        check("rst_upd_ovf", 32'(upd_ovf), 32'h0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 19; v++) begin
            if (vecs[v].upd) push(vecs[v].idx, vecs[v].code);
            apply(vecs[v].seg, vecs[v].sel, vecs[v].dwell);
            apply(7'h00, 4'b0000, vecs[v].gap);
            check($sformatf("vec%0d_digit", v), 32'(bcd_out[4*vecs[v].idx +: 4]), 32'(vecs[v].code));
            check($sformatf("vec%0d_valid", v), 32'(digit_valid[vecs[v].idx]), 32'(vecs[v].code <= 4'd9));
            if (v == 8) begin
                check("scan_bcd_out", 32'(bcd_out), 32'h4321);
                check("scan_valid", 32'(digit_valid), 32'hF);
            end
        end
        step();
        check("table_updates_drained", 32'(exp_q.size()), 32'h0);
        check("table_no_error", 32'(err_flag), 32'h0);

        // Invalid pattern, sticky error, clear, and clear colliding with a new error.
        push(2, 4'hE);
        apply(7'h15, 4'b0100, 6);
        apply(7'h00, 4'b0000, 2);
        check("inv_digit2", 32'(bcd_out[11:8]), 32'hE);
        check("inv_valid2", 32'(digit_valid[2]), 32'h0);
        check("inv_err_set", 32'(err_flag), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", 32'(err_flag), 32'h0);
        push(1, 4'hE);
        err_clr = 1'b1;
        apply(7'h15, 4'b0010, 5);
        err_clr = 1'b0;
        apply(7'h00, 4'b0000, 2);
        check("err_set_wins", 32'(err_flag), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Back-pressure: overwrite sets overflow, then accept and new capture in the same cycle.
        upd_ready = 1'b0;
        apply(7'h7E, 4'b0001, 6);
        apply(7'h00, 4'b0000, 2);
        check("bp_first_valid", 32'(upd_valid), 32'h1);
        check("bp_first_idx", 32'(upd_idx), 32'h0);
        check("bp_first_bcd", 32'(upd_bcd), 32'h0);
        check("bp_first_ovf", 32'(upd_ovf), 32'h0);
        apply(7'h33, 4'b1000, 6);
        apply(7'h00, 4'b0000, 2);
        check("ovf_idx", 32'(upd_idx), 32'h3);
        check("ovf_bcd", 32'(upd_bcd), 32'h4);
        check("ovf_set", 32'(upd_ovf), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_cleared", 32'(upd_ovf), 32'h0);
        check("ovf_hold_valid", 32'(upd_valid), 32'h1);
        check("ovf_hold_bcd", 32'(upd_bcd), 32'h4);
        push(3, 4'h4);
        apply(7'h6D, 4'b0010, 4);
        upd_ready = 1'b1;
        step();
        upd_ready = 1'b0;
        step();
        check("same_cycle_valid", 32'(upd_valid), 32'h1);
        check("same_cycle_idx", 32'(upd_idx), 32'h1);
        check("same_cycle_bcd", 32'(upd_bcd), 32'h2);
        check("same_cycle_no_ovf", 32'(upd_ovf), 32'h0);
        push(1, 4'h2);
        upd_ready = 1'b1;
        apply(7'h00, 4'b0000, 3);
        check("drained_valid", 32'(upd_valid), 32'h0);
        check("bp_updates_drained", 32'(exp_q.size()), 32'h0);

        // Reset with an error set, an update pending and a digit mid-settle.
        upd_ready = 1'b0;
        apply(7'h15, 4'b0001, 6);
        apply(7'h7F, 4'b0011, 3);
        apply(7'h7E, 4'b0100, 2);
        check("pre_rst_pending", 32'(upd_valid), 32'h1);
        check("pre_rst_err", 32'(err_flag), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd_out", 32'(bcd_out), 32'hFFFF);
        check("async_rst_valid", 32'(digit_valid), 32'h0);
        check("async_rst_err", 32'(err_flag), 32'h0);
        check("async_rst_upd_valid", 32'(upd_valid), 32'h0);
        check("async_rst_upd_idx", 32'(upd_idx), 32'h0);
        check("async_rst_upd_bcd", 32'(upd_bcd), 32'h0);
        seg_in  = '0;
        dig_sel = '0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("post_rst_bcd_out", 32'(bcd_out), 32'hFFFF);
        check("post_rst_upd_valid", 32'(upd_valid), 32'h0);
        check("post_rst_ovf", 32'(upd_ovf), 32'h0);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
